// File: rtl/serial_bit_transmitter.sv
// Parallel-to-serial frame transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit,
// each bit held for CLKS_PER_BIT clocks on a registered tx line.
module serial_bit_transmitter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  // Counters are sized to their terminal values so no legal parameter can overflow them.
  localparam int unsigned CycW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                  state_q;
  logic [CycW-1:0]         cyc_q;
  logic [BitW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_nxt;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    period_end;

  assign shift_nxt  = shift_q >> 1;
  assign period_end = (cyc_q == CycLast);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= data_in;
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (period_end) begin
            cyc_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StData: begin
          if (period_end) begin
            cyc_q   <= '0;
            shift_q <= shift_nxt;
            if (bit_q == BitLast) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + BitW'(1);
              tx_q  <= shift_nxt[0];
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StStop: begin
          if (period_end) begin
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_bit_transmitter.sv
// Bench for serial_bit_transmitter: frame-level model compared every cycle, plus hand-computed
// bit sequences for the 8x4 and 4x1 configurations.
module tb_serial_bit_transmitter;

  localparam int DwA = 8;
  localparam int CpbA = 4;
  localparam int FrameA = (DwA + 2) * CpbA;
  localparam int DwB = 4;
  localparam int CpbB = 1;
  localparam int FrameB = (DwB + 2) * CpbB;

  logic       clock;
  logic       reset;
  logic       start_a, start_b;
  logic [7:0] data_a;
  logic [3:0] data_b;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  serial_bit_transmitter #(
    .DATA_WIDTH  (DwA),
    .CLKS_PER_BIT(CpbA)
  ) u_dut_a (
    .clock  (clock),
    .reset  (reset),
    .start  (start_a),
    .data_in(data_a),
    .tx     (tx_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  serial_bit_transmitter #(
    .DATA_WIDTH  (DwB),
    .CLKS_PER_BIT(CpbB)
  ) u_dut_b (
    .clock  (clock),
    .reset  (reset),
    .start  (start_b),
    .data_in(data_b),
    .tx     (tx_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a frame is a fixed list of bits; remaining cycles and elapsed cycles locate the bit.
  int         ma_left, ma_pos, mb_left, mb_pos;
  logic [9:0] ma_frame;
  logic [5:0] mb_frame;
  logic       ma_done, mb_done;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ma_left <= 0; ma_pos <= 0; ma_done <= 1'b0; ma_frame <= '1;
    end else begin
      ma_done <= 1'b0;
      if (ma_left > 0) begin
        ma_left <= ma_left - 1;
        ma_pos  <= ma_pos + 1;
        if (ma_left == 1) ma_done <= 1'b1;
      end else if (start_a) begin
        ma_left  <= FrameA;
        ma_pos   <= 0;
        ma_frame <= {1'b1, data_a, 1'b0};
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mb_left <= 0; mb_pos <= 0; mb_done <= 1'b0; mb_frame <= '1;
    end else begin
      mb_done <= 1'b0;
      if (mb_left > 0) begin
        mb_left <= mb_left - 1;
        mb_pos  <= mb_pos + 1;
        if (mb_left == 1) mb_done <= 1'b1;
      end else if (start_b) begin
        mb_left  <= FrameB;
        mb_pos   <= 0;
        mb_frame <= {1'b1, data_b, 1'b0};
      end
    end
  end

  function automatic logic exp_tx(input int left, input int pos, input logic [33:0] frame,
                                  input int cpb);
    return (left > 0) ? frame[pos / cpb] : 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // seq[i] is the i-th bit on the line; busy for 40 cycles, done on the 41st.
  task automatic frame_a(input logic [9:0] seq, input string tag, input int change_at,
                         input logic [7:0] new_data, input bit drop_start);
    for (int c = 0; c < FrameA; c++) begin
      @(negedge clock);
      if (c == 0 && drop_start) start_a = 1'b0;
      if (c == change_at) data_a = new_data;
      check({tag, " tx"}, 32'(tx_a), 32'(seq[c / CpbA]));
      check({tag, " busy"}, 32'(busy_a), 32'd1);
      check({tag, " done low"}, 32'(done_a), 32'd0);
    end
    @(negedge clock);
    check({tag, " done pulse"}, 32'(done_a), 32'd1);
    check({tag, " busy fall"}, 32'(busy_a), 32'd0);
    check({tag, " idle tx"}, 32'(tx_a), 32'd1);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
      forever begin
        @(negedge clock);
        check("model tx_a", 32'(tx_a), 32'(exp_tx(ma_left, ma_pos, {24'b0, ma_frame}, CpbA)));
        check("model busy_a", 32'(busy_a), 32'(ma_left > 0));
        check("model done_a", 32'(done_a), 32'(ma_done));
        check("model tx_b", 32'(tx_b), 32'(exp_tx(mb_left, mb_pos, {28'b0, mb_frame}, CpbB)));
        check("model busy_b", 32'(busy_b), 32'(mb_left > 0));
        check("model done_b", 32'(done_b), 32'(mb_done));
      end
    join_none
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    #1 reset = 1'b0;

    // Reset and idle.
    repeat (3) begin
      @(negedge clock);
      check("reset tx", 32'(tx_a), 32'd1);
      check("reset busy", 32'(busy_a), 32'd0);
      check("reset done", 32'(done_a), 32'd0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle tx", 32'(tx_a), 32'd1);

    // A5 -> 0,1,0,1,0,0,1,0,1,1
    start_a = 1'b1; data_a = 8'hA5;
    frame_a(10'b1101001010, "a5", -1, 8'h00, 1'b1);
    repeat (2) @(negedge clock);

    // start held high, data_in changed mid-frame; the FF frame follows the done cycle.
    start_a = 1'b1; data_a = 8'h3C;
    frame_a(10'b1001111000, "3c", 20, 8'hFF, 1'b0);
    frame_a(10'b1111111110, "ff", -1, 8'hFF, 1'b0);
    start_a = 1'b0;
    repeat (2) @(negedge clock);

    // Back-to-back: start raised in the done cycle of the 80 frame.
    start_a = 1'b1; data_a = 8'h80;
    frame_a(10'b1100000000, "80", -1, 8'h00, 1'b1);
    start_a = 1'b1; data_a = 8'h01;
    frame_a(10'b1000000010, "01", -1, 8'h00, 1'b1);
    repeat (2) @(negedge clock);

    // Reset during data bit 3 (cycles 16..19) of 0F.
    start_a = 1'b1; data_a = 8'h0F;
    @(negedge clock);
    start_a = 1'b0;
    repeat (17) @(negedge clock);
    check("pre-abort busy", 32'(busy_a), 32'd1);
    check("pre-abort tx bit3", 32'(tx_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset tx", 32'(tx_a), 32'd1);
    check("async reset busy", 32'(busy_a), 32'd0);
    check("async reset done", 32'(done_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("aborted no done", 32'(done_a), 32'd0);
      check("aborted idle busy", 32'(busy_a), 32'd0);
    end
    start_a = 1'b1; data_a = 8'hA5;
    frame_a(10'b1101001010, "after abort", -1, 8'h00, 1'b1);
    repeat (2) @(negedge clock);

    // CLKS_PER_BIT=1, DATA_WIDTH=4, 1001 -> 0,1,0,0,1,1
    begin
      logic [5:0] seq_b;
      seq_b = 6'b110010;
      start_b = 1'b1; data_b = 4'b1001;
      for (int c = 0; c < FrameB; c++) begin
        @(negedge clock);
        if (c == 0) start_b = 1'b0;
        check("cpb1 tx", 32'(tx_b), 32'(seq_b[c]));
        check("cpb1 busy", 32'(busy_b), 32'd1);
        check("cpb1 done low", 32'(done_b), 32'd0);
      end
      @(negedge clock);
      check("cpb1 done pulse", 32'(done_b), 32'd1);
      check("cpb1 busy fall", 32'(busy_b), 32'd0);
      @(negedge clock);
      check("cpb1 done single", 32'(done_b), 32'd0);
    end

    repeat (3) @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
